// File: rtl/memory_stage.sv
// Memory stage: forwards non-memory results in one cycle and runs load/store
// transactions on a req/ack data bus with a bounded wait.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] rd_data,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [4:0]         rd_q, rd_d;
    logic [1:0]         lane_q, lane_d;
    logic               is_load_q, is_load_d;

    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [31:0]        dmem_addr_q, dmem_addr_d;
    logic [3:0]         dmem_be_q, dmem_be_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_we_q, wb_we_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;

    logic        is_load, is_store, is_mem;
    logic        f3_legal, addr_ok, timed_out;
    logic [1:0]  a;
    logic [31:0] lane_word, load_value;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign a        = mem_addr[1:0];

    // Only byte/half/word widths exist; loads add the unsigned byte/half forms.
    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                    || (funct3 == 3'b100) || (funct3 == 3'b101);
        end else if (is_store) begin
            f3_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   addr_ok = 1'b1;
            2'b01:   addr_ok = (a[0] == 1'b0);
            default: addr_ok = (a == 2'b00);
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << a;
                store_wdata = {4{mem_out[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << a;
                store_wdata = {2{mem_out[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = mem_out;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then size/extend it.
    assign lane_word = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_value = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_value = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_value = {24'd0, lane_word[7:0]};
            3'b101:  load_value = {16'd0, lane_word[15:0]};
            default: load_value = dmem_rdata;
        endcase
    end

    assign timed_out = ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        rd_d         = rd_q;
        lane_d       = lane_q;
        is_load_d    = is_load_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = 5'd0;
        wb_data_d    = 32'd0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wb_rd_d = rd;
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = rd_data;
                        wb_we_d    = (rd != 5'd0) && (opcode != OP_BRANCH);
                    end else if (!f3_legal || !addr_ok) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d      = ACCESS;
                        cnt_d        = '0;
                        f3_d         = funct3;
                        rd_d         = rd;
                        lane_d       = a;
                        is_load_d    = is_load;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {mem_addr[31:2], 2'b00};
                        dmem_be_d    = is_store ? store_be : 4'b1111;
                        dmem_wdata_d = is_store ? store_wdata : 32'd0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack || timed_out) begin
                    state_d      = IDLE;
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = 32'd0;
                    dmem_be_d    = 4'd0;
                    dmem_wdata_d = 32'd0;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    // A late ack on the timeout edge still completes the access.
                    if (dmem_ack) begin
                        if (is_load_q) begin
                            wb_we_d   = (rd_q != 5'd0);
                            wb_data_d = load_value;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'd0;
            rd_q         <= 5'd0;
            lane_q       <= 2'd0;
            is_load_q    <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            rd_q         <= rd_d;
            lane_q       <= lane_d;
            is_load_q    <= is_load_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage; expected results come from a width/alignment
// model of the load/store rules, with directed cases for the corner behaviours.
module tb_memory_stage;
    localparam int TO = 4;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] rd_data = '0, mem_addr = '0, mem_out = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid, wb_we, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_out(mem_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Access width in bytes; 0 means the funct3 is not a legal access for this opcode.
    function automatic int acc_size(input logic [6:0] op, input logic [2:0] f3);
        int f = int'(f3);
        if (op == OP_LOAD) begin
            if (f == 0 || f == 4) return 1;
            if (f == 1 || f == 5) return 2;
            if (f == 2) return 4;
            return 0;
        end
        if (op == OP_STORE) return (f <= 2) ? (1 << f) : 0;
        return 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rdat);
        int sz = acc_size(OP_LOAD, f3);
        longint v = longint'(rdat >> (8 * int'(a)));
        longint lim = longint'(1) << (8 * sz);
        v = v % lim;
        if (f3[2] == 1'b0 && sz < 4 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                           input logic [31:0] rdv, input logic [31:0] addr,
                           input logic [31:0] mout, input int ack_dly,
                           input logic [31:0] rdat);
        int sz = acc_size(op, f3);
        bit mem = (op == OP_LOAD) || (op == OP_STORE);
        bit bad = mem && (sz == 0 || (int'(addr[1:0]) % (sz == 0 ? 1 : sz)) != 0);
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        bit done;
        @(negedge clk);
        check("in_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; opcode = op; funct3 = f3; rd = r;
        rd_data = rdv; mem_addr = addr; mem_out = mout;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'b0;
        $display("txn op=%07b f3=%0d rd=%0d addr=%08h ack_dly=%0d", op, f3, r, addr, ack_dly);
        if (!mem) begin
            check("nm_valid", {31'd0, wb_valid}, 32'd1);
            check("nm_we", {31'd0, wb_we}, {31'd0, (r != 0) && (op != OP_BRANCH)});
            check("nm_rd", {27'd0, wb_rd}, {27'd0, r});
            check("nm_data", wb_data, rdv);
            check("nm_req", {31'd0, dmem_req}, 32'd0);
            check("nm_misalign", {31'd0, misalign}, 32'd0);
        end else if (bad) begin
            check("mis_pulse", {31'd0, misalign}, 32'd1);
            check("mis_valid", {31'd0, wb_valid}, 32'd1);
            check("mis_we", {31'd0, wb_we}, 32'd0);
            check("mis_req", {31'd0, dmem_req}, 32'd0);
            check("mis_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            exp_be = (op == OP_STORE) ? 4'(((1 << sz) - 1) << int'(addr[1:0])) : 4'hF;
            exp_wd = 32'd0;
            if (op == OP_STORE)
                exp_wd = (sz == 1) ? {4{mout[7:0]}} : (sz == 2) ? {2{mout[15:0]}} : mout;
            check("req_on", {31'd0, dmem_req}, 32'd1);
            check("req_we", {31'd0, dmem_we}, {31'd0, op == OP_STORE});
            check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_be", {28'd0, dmem_be}, {28'd0, exp_be});
            check("req_wdata", dmem_wdata, exp_wd);
            check("req_ready", {31'd0, in_ready}, 32'd0);
            check("req_novalid", {31'd0, wb_valid}, 32'd0);
            done = 1'b0;
            for (int k = 1; k <= TO && !done; k++) begin
                if (k == ack_dly) dmem_rdata = rdat;
                else dmem_rdata = $urandom;
                dmem_ack = (k == ack_dly);
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (k == ack_dly || k == TO) done = 1'b1;
                else begin
                    check("wait_req", {31'd0, dmem_req}, 32'd1);
                    check("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                    check("wait_novalid", {31'd0, wb_valid}, 32'd0);
                end
            end
            check("end_req", {31'd0, dmem_req}, 32'd0);
            check("end_valid", {31'd0, wb_valid}, 32'd1);
            check("end_rd", {27'd0, wb_rd}, {27'd0, r});
            check("end_ready", {31'd0, in_ready}, 32'd1);
            if (ack_dly <= TO) begin
                check("ack_buserr", {31'd0, bus_err}, 32'd0);
                check("ack_we", {31'd0, wb_we}, {31'd0, (op == OP_LOAD) && (r != 0)});
                check("ack_data", wb_data, (op == OP_LOAD) ? load_model(f3, addr[1:0], rdat) : 32'd0);
            end else begin
                check("to_buserr", {31'd0, bus_err}, 32'd1);
                check("to_we", {31'd0, wb_we}, 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [6];
        ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_ADDI;
        ops[3] = 7'b0110011; ops[4] = OP_BRANCH; ops[5] = 7'b1101111;

        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_data", wb_data, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_txn(OP_ADDI, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 32'h0);
        run_txn(OP_ADDI, 3'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 0, 32'h0);
        run_txn(OP_BRANCH, 3'd1, 5'd3, 32'h55, 32'h0, 32'h0, 0, 32'h0);
        run_txn(OP_LOAD, 3'd0, 5'd7, 32'h0, 32'h103, 32'h0, 3, 32'h80FF_0000);
        run_txn(OP_LOAD, 3'd4, 5'd7, 32'h0, 32'h103, 32'h0, 3, 32'h80FF_0000);
        run_txn(OP_STORE, 3'd1, 5'd0, 32'h0, 32'h202, 32'hABCD, 2, 32'h0);
        run_txn(OP_LOAD, 3'd2, 5'd9, 32'h0, 32'h101, 32'h0, 1, 32'h0);
        run_txn(OP_LOAD, 3'd3, 5'd9, 32'h0, 32'h100, 32'h0, 1, 32'h0);
        run_txn(OP_LOAD, 3'd2, 5'd4, 32'h0, 32'h300, 32'h0, 99, 32'h0);
        run_txn(OP_LOAD, 3'd1, 5'd6, 32'h0, 32'h402, 32'h0, TO, 32'h8001_7FFF);
        run_txn(OP_LOAD, 3'd2, 5'd8, 32'h0, 32'h500, 32'h0, 1, 32'hDEAD_BEEF);

        // Reset in the middle of a wait: request must vanish, late ack ignored.
        @(negedge clk);
        in_valid = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; rd = 5'd3; mem_addr = 32'h40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_req_on", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1; #1;
        check("abort_req_off", {31'd0, dmem_req}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0; dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("late_ack_valid", {31'd0, wb_valid}, 32'd0);
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        check("late_ack_valid2", {31'd0, wb_valid}, 32'd0);

        // Accept on the very first edge after reset release.
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; opcode = OP_ADDI; rd = 5'd12; rd_data = 32'hCAFE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_edge_valid", {31'd0, wb_valid}, 32'd1);
        check("first_edge_data", wb_data, 32'hCAFE);
        @(posedge clk); #1;
        check("pulse_drop", {31'd0, wb_valid}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [6:0] op = ops[$urandom_range(0, 5)];
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_txn(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
                    addr, $urandom, $urandom_range(1, TO + 2), $urandom);
        end

        @(posedge clk); #1;
        check("final_idle_valid", {31'd0, wb_valid}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
